// File: rtl/cpu_datapath.sv
// cpu_datapath -- 8-bit datapath executing the control unit's 16-bit control word.
//
// Shared OR-bus, MAR, MBR, IR, PC, D0, registered ALU with Z/C flags and a
// MEM_DEPTH-byte program/data memory with a bootload write port. MEM_DEPTH must
// be 16 so that the 4-bit address matches the IR operand field.
//
// Ports:
//   slowclk        system clock, rising edge
//   nReset         asynchronous active-low reset (memory is not reset)
//   ControlSignals control word: [1:0] FF, [7:2] bus enables EALU..EMSR,
//                  [13:8] loads CALU..CMAR, [14] W, [15] R
//   Bootload       1 = control word ignored, PC/MAR held at 0, boot port active
//   boot_we/boot_addr/boot_data  bootload memory write port
//   ir_out, pc_out, d0_out       register contents
//   bus_out        combinational bus value (0 while bootloading)
//   z_flag, c_flag ALU zero and carry/borrow flags (updated only on CALU)
//   bus_err        sticky bus contention flag
//
// Optional feature: define CPU_DATAPATH_BUSCHECK_EN to build contention
// detection; otherwise bus_err is tied to 0.
module cpu_datapath #(
   parameter int unsigned MEM_DEPTH = 16
) (
   input  logic        slowclk,
   input  logic        nReset,
   input  logic [15:0] ControlSignals,
   input  logic        Bootload,
   input  logic        boot_we,
   input  logic [3:0]  boot_addr,
   input  logic [7:0]  boot_data,
   output logic [7:0]  ir_out,
   output logic [3:0]  pc_out,
   output logic [7:0]  d0_out,
   output logic [7:0]  bus_out,
   output logic        z_flag,
   output logic        c_flag,
   output logic        bus_err
);

   localparam logic [1:0] FfAdd  = 2'b00;
   localparam logic [1:0] FfSub  = 2'b01;
   localparam logic [1:0] FfInc  = 2'b10;
   localparam logic [1:0] FfPass = 2'b11;

   logic [7:0] mem_q [MEM_DEPTH];
   logic [3:0] mar_q, mar_d, pc_q, pc_d;
   logic [7:0] mbr_q, mbr_d, ir_q, ir_d, d0_q, d0_d, alu_q, alu_d;
   logic       z_q, z_d, c_q, c_d;

   // While bootloading the control word is masked to zero, which also forces the bus to 0.
   logic [15:0] cw;
   assign cw = Bootload ? 16'h0000 : ControlSignals;

   logic [1:0] ff;
   logic e_alu, e_d0, e_pc, e_ir, e_mbr, e_msr;
   logic c_alu, c_d0, c_ir, c_pc, c_br, c_mar, wr, rd;

   assign ff    = cw[1:0];
   assign e_alu = cw[2];
   assign e_d0  = cw[3];
   assign e_pc  = cw[4];
   assign e_ir  = cw[5];
   assign e_mbr = cw[6];
   assign e_msr = cw[7];
   assign c_alu = cw[8];
   assign c_d0  = cw[9];
   assign c_ir  = cw[10];
   assign c_pc  = cw[11];
   assign c_br  = cw[12];
   assign c_mar = cw[13];
   assign wr    = cw[14];
   assign rd    = cw[15];

   // Wired-OR bus; memory drives only when both EMSR and R are set.
   logic [7:0] bus;
   always_comb begin
      bus = 8'h00;
      if (e_alu)      bus = bus | alu_q;
      if (e_d0)       bus = bus | d0_q;
      if (e_pc)       bus = bus | {4'b0000, pc_q};
      if (e_ir)       bus = bus | {4'b0000, ir_q[3:0]};
      if (e_mbr)      bus = bus | mbr_q;
      if (e_msr & rd) bus = bus | mem_q[mar_q];
   end

   // Bit 8 is carry-out for add/inc and borrow for sub (zero-extended subtraction).
   logic [8:0] alu_sum;
   always_comb begin
      alu_sum = 9'h000;
      case (ff)
         FfAdd:   alu_sum = {1'b0, d0_q} + {1'b0, bus};
         FfSub:   alu_sum = {1'b0, d0_q} - {1'b0, bus};
         FfInc:   alu_sum = {1'b0, bus} + 9'h001;
         FfPass:  alu_sum = {1'b0, bus};
         default: alu_sum = 9'h000;
      endcase
   end

   always_comb begin
      mar_d = mar_q;
      pc_d  = pc_q;
      mbr_d = mbr_q;
      ir_d  = ir_q;
      d0_d  = d0_q;
      alu_d = alu_q;
      z_d   = z_q;
      c_d   = c_q;
      if (Bootload) begin
         mar_d = 4'h0;
         pc_d  = 4'h0;
      end else begin
         if (c_mar) mar_d = bus[3:0];
         if (c_pc)  pc_d  = bus[3:0];
         if (c_br)  mbr_d = bus;
         if (c_ir)  ir_d  = bus;
         if (c_d0)  d0_d  = bus;
         if (c_alu) begin
            alu_d = alu_sum[7:0];
            c_d   = alu_sum[8];
            z_d   = (alu_sum[7:0] == 8'h00);
         end
      end
   end

   always_ff @(posedge slowclk or negedge nReset) begin
      if (!nReset) begin
         mar_q <= 4'h0;
         pc_q  <= 4'h0;
         mbr_q <= 8'h00;
         ir_q  <= 8'h00;
         d0_q  <= 8'h00;
         alu_q <= 8'h00;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
      end else begin
         mar_q <= mar_d;
         pc_q  <= pc_d;
         mbr_q <= mbr_d;
         ir_q  <= ir_d;
         d0_q  <= d0_d;
         alu_q <= alu_d;
         z_q   <= z_d;
         c_q   <= c_d;
      end
   end

   // Memory survives reset so a bootloaded program persists across nReset.
   always_ff @(posedge slowclk) begin
      if (Bootload) begin
         if (boot_we) mem_q[boot_addr] <= boot_data;
      end else if (wr) begin
         mem_q[mar_q] <= bus;
      end
   end

`ifdef CPU_DATAPATH_BUSCHECK_EN
   logic [5:0] drv;
   logic       multi_drv;
   logic       bus_err_q;
   assign drv       = {e_alu, e_d0, e_pc, e_ir, e_mbr, e_msr & rd};
   // More than one bit set: clearing the lowest set bit leaves something.
   assign multi_drv = (drv & (drv - 6'd1)) != 6'd0;

   always_ff @(posedge slowclk or negedge nReset) begin
      if (!nReset)        bus_err_q <= 1'b0;
      else if (multi_drv) bus_err_q <= 1'b1;
   end
   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

   assign ir_out  = ir_q;
   assign pc_out  = pc_q;
   assign d0_out  = d0_q;
   assign bus_out = bus;
   assign z_flag  = z_q;
   assign c_flag  = c_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Testbench for cpu_datapath: table of control words with expected bus values and
// post-edge register values, scored through a queue, plus hand-written reset and
// bootload sequences.
module tb_cpu_datapath;

   localparam logic [15:0] FAdd = 16'h0000, FSub = 16'h0001, FInc = 16'h0002, FPass = 16'h0003;
   localparam logic [15:0] EALU = 16'h0004, ED0 = 16'h0008, EPC = 16'h0010, EIR = 16'h0020;
   localparam logic [15:0] EMBR = 16'h0040, EMSR = 16'h0080;
   localparam logic [15:0] CALU = 16'h0100, CD0 = 16'h0200, CIR = 16'h0400, CPC = 16'h0800;
   localparam logic [15:0] CBR = 16'h1000, CMAR = 16'h2000, WR = 16'h4000, RD = 16'h8000;

   localparam int SNone = 0, SIr = 1, SPc = 2, SD0 = 3, SZ = 4, SC = 5, SErr = 6;

`ifdef CPU_DATAPATH_BUSCHECK_EN
   localparam logic [7:0] ExpErr = 8'd1;
`else
   localparam logic [7:0] ExpErr = 8'd0;
`endif

   logic        slowclk = 1'b0;
   logic        nReset;
   logic [15:0] ControlSignals;
   logic        Bootload, boot_we;
   logic [3:0]  boot_addr;
   logic [7:0]  boot_data;
   logic [7:0]  ir_out, d0_out, bus_out;
   logic [3:0]  pc_out;
   logic        z_flag, c_flag, bus_err;

   cpu_datapath #(.MEM_DEPTH(16)) dut (
      .slowclk        (slowclk),
      .nReset         (nReset),
      .ControlSignals (ControlSignals),
      .Bootload       (Bootload),
      .boot_we        (boot_we),
      .boot_addr      (boot_addr),
      .boot_data      (boot_data),
      .ir_out         (ir_out),
      .pc_out         (pc_out),
      .d0_out         (d0_out),
      .bus_out        (bus_out),
      .z_flag         (z_flag),
      .c_flag         (c_flag),
      .bus_err        (bus_err)
   );

   always #5 slowclk = ~slowclk;

   typedef struct {
      logic [15:0] cw;
      logic [7:0]  bexp;
      int          s1;
      logic [7:0]  e1;
      int          s2;
      logic [7:0]  e2;
   } vec_t;

   typedef struct {
      int         sel;
      logic [7:0] val;
      int         idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] act_of(input int s);
      case (s)
         SIr:     return ir_out;
         SPc:     return {4'h0, pc_out};
         SD0:     return d0_out;
         SZ:      return {7'h0, z_flag};
         SC:      return {7'h0, c_flag};
         SErr:    return {7'h0, bus_err};
         default: return 8'hxx;
      endcase
   endfunction

   function automatic string sel_name(input int s);
      case (s)
         SIr:     return "ir";
         SPc:     return "pc";
         SD0:     return "d0";
         SZ:      return "z";
         SC:      return "c";
         SErr:    return "bus_err";
         default: return "?";
      endcase
   endfunction

   task automatic add(input logic [15:0] cw, input logic [7:0] bexp,
                      input int s1 = SNone, input logic [7:0] e1 = 8'h00,
                      input int s2 = SNone, input logic [7:0] e2 = 8'h00);
      vec_t v;
      v.cw = cw; v.bexp = bexp; v.s1 = s1; v.e1 = e1; v.s2 = s2; v.e2 = e2;
      vecs.push_back(v);
   endtask

   // Five-word fetch from PC=p where mem[p]=m.
   task automatic add_fetch(input logic [3:0] p, input logic [7:0] m);
      add(EPC | CMAR, {4'h0, p});
      add(RD | EMSR | CBR, m);
      add(EMBR | CIR, m, SIr, m);
      add(EPC | CALU | FInc, {4'h0, p});
      add(EALU | CPC, {4'h0, p} + 8'd1, SPc, {4'h0, p + 4'd1});
   endtask

   // Drive one word at negedge, check the bus, queue expectations, score after the edge.
   task automatic step(input vec_t v, input int idx);
      exp_t e;
      @(negedge slowclk);
      ControlSignals = v.cw;
      #1;
      check($sformatf("bus[%0d]", idx), bus_out, v.bexp);
      if (v.s1 != SNone) begin e.sel = v.s1; e.val = v.e1; e.idx = idx; sb.push_back(e); end
      if (v.s2 != SNone) begin e.sel = v.s2; e.val = v.e2; e.idx = idx; sb.push_back(e); end
      @(posedge slowclk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("%s[%0d]", sel_name(e.sel), e.idx), act_of(e.sel), e.val);
      end
   endtask

   task automatic run_vecs(input int base);
      for (int i = 0; i < vecs.size(); i++) step(vecs[i], base + i);
      vecs.delete();
   endtask

   logic [3:0] img_a [13];
   logic [7:0] img_d [13];

   initial begin
      img_a = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      img_d = '{8'h1A, 8'h2E, 8'h2D, 8'h10, 8'h2C, 8'h2B, 8'h2B, 8'h0F,
                8'h00, 8'h5C, 8'h20, 8'hF0, 8'h80};

      nReset = 1'b0; ControlSignals = 16'h0; Bootload = 1'b0;
      boot_we = 1'b0; boot_addr = 4'h0; boot_data = 8'h00;
      repeat (2) @(negedge slowclk);
      nReset = 1'b1;
      #1;
      check("rst_ir", ir_out, 8'h00);
      check("rst_pc", {4'h0, pc_out}, 8'h00);
      check("rst_d0", d0_out, 8'h00);
      check("rst_z", {7'h0, z_flag}, 8'h00);
      check("rst_c", {7'h0, c_flag}, 8'h00);
      check("rst_err", {7'h0, bus_err}, 8'h00);
      check("rst_bus", bus_out, 8'h00);

      // Bootload the program image.
      @(negedge slowclk);
      Bootload = 1'b1;
      for (int i = 0; i < 13; i++) begin
         boot_we = 1'b1; boot_addr = img_a[i]; boot_data = img_d[i];
         @(negedge slowclk);
      end
      boot_we = 1'b0;
      Bootload = 1'b0;

      add_fetch(4'h0, 8'h1A);                                      // IR=1A, PC=1
      add_fetch(4'h1, 8'h2E);                                      // LDA E
      add(EIR | CMAR, 8'h0E);
      add(RD | EMSR | CBR, 8'hF0);
      add(EMBR | CALU | FPass, 8'hF0, SZ, 8'd0, SC, 8'd0);
      add(EALU | CD0, 8'hF0, SD0, 8'hF0);
      add_fetch(4'h2, 8'h2D);                                      // ADD D
      add(EIR | CMAR, 8'h0D);
      add(RD | EMSR | CBR, 8'h20);
      add(EMBR | CALU | FAdd, 8'h20, SC, 8'd1, SZ, 8'd0);
      add(EALU | CD0, 8'h10, SD0, 8'h10);
      add(EPC | CMAR, 8'h03);                                      // SUB immediate byte
      add(RD | EMSR | CBR, 8'h10);
      add(EMBR | CALU | FSub, 8'h10, SZ, 8'd1, SC, 8'd0);
      add(EALU | CD0, 8'h00, SD0, 8'h00);
      add(EPC | CALU | FInc, 8'h03);
      add(EALU | CPC, 8'h04, SPc, 8'h04);
      add_fetch(4'h4, 8'h2C);                                      // LDA C
      add(EIR | CMAR, 8'h0C);
      add(RD | EMSR | CBR, 8'h5C);
      add(EMBR | CALU | FPass, 8'h5C);
      add(EALU | CD0, 8'h5C, SD0, 8'h5C);
      add_fetch(4'h5, 8'h2B);                                      // STA B
      add(EIR | CMAR, 8'h0B);
      add(ED0 | WR, 8'h5C);
      add(ED0 | CALU | FSub, 8'h5C, SZ, 8'd1, SC, 8'd0);           // D0 - D0
      add(EALU | CD0, 8'h00, SD0, 8'h00);
      add_fetch(4'h6, 8'h2B);                                      // LDA B
      add(EIR | CMAR, 8'h0B);
      add(RD | EMSR | CBR, 8'h5C);
      add(EMBR | CALU | FPass, 8'h5C);
      add(EALU | CD0, 8'h5C, SD0, 8'h5C);
      add(EPC | CMAR, 8'h07);                                      // PC <= 15
      add(RD | EMSR | CBR, 8'h0F);
      add(EMBR | CPC, 8'h0F, SPc, 8'h0F);
      add(EPC | CALU | FInc, 8'h0F, SC, 8'd0, SZ, 8'd0);           // wrap
      add(EALU | CPC, 8'h10, SPc, 8'h00);
      add(EALU | CALU | FInc, 8'h10, SZ, 8'd0, SC, 8'd0);          // bus sees old ALU value
      add(EALU, 8'h11);
      add(EMBR | CMAR, 8'h0F);                                     // D0 <= mem[F]=80
      add(RD | EMSR | CBR, 8'h80);
      add(EMBR | CD0, 8'h80, SD0, 8'h80, SErr, 8'd0);
      for (int k = 0; k < 3; k++) begin                            // PC 0 -> 3
         add(EPC | CALU | FInc, 8'(k));
         add(EALU | CPC, 8'(k + 1), SPc, 8'(k + 1));
      end
      add(ED0 | EPC, 8'h83, SErr, ExpErr);                         // contention
      add(ED0, 8'h80, SErr, ExpErr);                               // sticky
      add(EPC | CMAR, 8'h03);                                      // fetch words 1, 2
      add(RD | EMSR | CBR, 8'h10);
      run_vecs(0);

      // Asynchronous reset mid-fetch.
      @(negedge slowclk);
      ControlSignals = 16'h0;
      nReset = 1'b0;
      #1;
      check("mid_rst_ir", ir_out, 8'h00);
      check("mid_rst_pc", {4'h0, pc_out}, 8'h00);
      check("mid_rst_d0", d0_out, 8'h00);
      check("mid_rst_c", {7'h0, c_flag}, 8'h00);
      check("mid_rst_err", {7'h0, bus_err}, 8'h00);
      @(negedge slowclk);
      nReset = 1'b1;

      add(EALU, 8'h00);                                            // ALU result cleared
      add_fetch(4'h0, 8'h1A);                                      // memory kept
      run_vecs(100);

      // boot_we ignored when Bootload=0.
      @(negedge slowclk);
      ControlSignals = 16'h0;
      boot_we = 1'b1; boot_addr = 4'h1; boot_data = 8'h55;
      @(negedge slowclk);
      boot_we = 1'b0;
      add(EPC | CMAR, 8'h01);
      add(RD | EMSR | CBR, 8'h2E);
      run_vecs(200);

      // Bootload masks the control word and holds PC at 0.
      @(negedge slowclk);
      Bootload = 1'b1;
      ControlSignals = EIR | CIR;
      #1;
      check("boot_bus", bus_out, 8'h00);
      @(posedge slowclk);
      #1;
      check("boot_pc", {4'h0, pc_out}, 8'h00);
      check("boot_ir", ir_out, 8'h1A);
      @(negedge slowclk);
      Bootload = 1'b0;
      #1;
      check("post_boot_bus", bus_out, 8'h0A);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
